// File: rtl/uart_rx_core.sv
// uart_rx_core: byte-level UART receiver for the K64 command link.
//
// Oversamples UART_RXD with the system clock, recovers 8N1 frames and presents
// each byte on a valid/ready holding register. Framing, parity and overrun
// errors drop the byte and pulse from_uart_error for one cycle.
//
// Build option:
//   UART_RX_PARITY_EN - when defined, frames are 8E1. A parity bit follows
//                       the data bits and must equal the XOR of the 8 data
//                       bits. When undefined, frames are 8N1.
//
// Parameters:
//   CLK_FREQ - system clock frequency in Hz
//   BAUD     - line rate; CLK_FREQ/BAUD must be >= 8
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - synchronous active-high reset
//   UART_RXD        - asynchronous serial input, idle high
//   from_uart_data  - received byte, valid while from_uart_valid is high
//   from_uart_valid - holding register full
//   from_uart_ready - consumer accepts the byte when valid && ready
//   from_uart_error - one-cycle framing/parity/overrun error pulse
module uart_rx_core #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic [7:0] from_uart_data,
  output logic       from_uart_valid,
  input  logic       from_uart_ready,
  output logic       from_uart_error
);

  localparam int unsigned Div = CLK_FREQ / BAUD;
  localparam logic [15:0] DivLast  = 16'(Div - 1);
  localparam logic [15:0] HalfLast = 16'(Div / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
`endif

  // rxd_meta_q/rxd_s_q form the synchronizer; rxd_d_q is one cycle older
  // than rxd_s_q and is only used to detect the start-bit falling edge.
  logic rxd_meta_q, rxd_s_q, rxd_d_q;

  logic [7:0] data_q;
  logic       valid_q;
  logic       err_q;

  logic frame_done;
  logic frame_ok;
  logic accept;

  assign accept = valid_q && from_uart_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_d_q    <= 1'b1;
    end else begin
      rxd_meta_q <= UART_RXD;
      rxd_s_q    <= rxd_meta_q;
      rxd_d_q    <= rxd_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    frame_done = 1'b0;
    frame_ok   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Only a 1->0 transition starts a frame, so a line held low after a
        // framing error (break) stays here until it rises and falls again.
        if (rxd_d_q && !rxd_s_q) begin
          state_d    = StStart;
          baud_cnt_d = '0;
        end
      end
      StStart: begin
        if (baud_cnt_q == HalfLast) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          // High at mid start bit means a glitch: drop it silently.
          state_d    = rxd_s_q ? StIdle : StData;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (baud_cnt_q == DivLast) begin
          baud_cnt_d = '0;
          shift_d    = {rxd_s_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (baud_cnt_q == DivLast) begin
          baud_cnt_d = '0;
          par_d      = rxd_s_q;
          state_d    = StStop;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
`endif
      StStop: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back
        // start edge.
        if (baud_cnt_q == DivLast) begin
          baud_cnt_d = '0;
          frame_done = 1'b1;
`ifdef UART_RX_PARITY_EN
          frame_ok   = rxd_s_q && (par_q == ^shift_q);
`else
          frame_ok   = rxd_s_q;
`endif
          state_d    = StIdle;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register: a new byte may load on the same edge the old one is
  // accepted; otherwise a full register drops the new byte (overrun).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= frame_done && (!frame_ok || (valid_q && !from_uart_ready));
      if (frame_done && frame_ok && (!valid_q || accept)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign from_uart_data  = data_q;
  assign from_uart_valid = valid_q;
  assign from_uart_error = err_q;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Byte-level UART receiver for the K64 command link: oversamples `UART_RXD`, recovers 8N1 frames (8E1 with parity compiled in) and presents each byte on the same valid/ready receive interface that the UART wrapper exposes to the control logic (`from_uart_data`/`from_uart_valid`/`from_uart_ready`/`from_uart_error`). It replaces the receive half of the packaged 115200 core so the receive path is fully owned, checkable RTL. It sits between the board RX pin and `uart_control`.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; `DIV = CLK_FREQ/BAUD` (integer truncation, 434 at defaults); `DIV >= 8` required.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `UART_RXD`  in  1  asynchronous serial input, idle high.
- `from_uart_data`  out  8  received byte; valid only while `from_uart_valid`=1.
- `from_uart_valid`  out  1  byte available in holding register.
- `from_uart_ready`  in  1  consumer accepts byte on any cycle with valid&&ready.
- `from_uart_error`  out  1  one-cycle pulse: framing, parity or overrun error.

## Operation
- `UART_RXD` passes a 2-FF synchronizer (`rxd_s`, set to 1 on reset); one further register `rxd_d` gives edge detect.
- Bit-time counter `baud_cnt` (16 bit) and bit index `bit_cnt` (3 bit); shift register LSB-first.
- States:
  - IDLE: `rxd_d`=1 && `rxd_s`=0 (falling edge) -> START, `baud_cnt`=0.
  - START: at `baud_cnt`=DIV/2-1 sample `rxd_s`; 0 -> DATA (`baud_cnt`=0, `bit_cnt`=0); 1 -> IDLE (glitch, no error).
  - DATA: at `baud_cnt`=DIV-1 sample bit into shifter, `baud_cnt`=0; after bit 7 -> PARITY (if compiled) else STOP.
  - PARITY: at DIV-1 sample parity bit -> STOP.
  - STOP: at DIV-1 sample stop bit -> IDLE. Stop=1 and parity OK -> deliver; stop=0 -> framing error; parity mismatch -> parity error. Error bytes are discarded (not delivered), `from_uart_error` pulses.
- Delivery: if holding register empty, or being accepted this same cycle (valid&&ready), load byte and set valid. Otherwise overrun: new byte dropped, old byte kept, error pulse.
- Handshake: valid, once set, stays high and data stable until the cycle valid&&ready; valid clears next edge unless a new byte loads that same edge (then valid stays 1, data updates).
- Return to IDLE after a framing error requires a new falling edge, so a held-low (break) line produces exactly one error, no further frames.

## Timing
- Reset values: `from_uart_data`=0x00, `from_uart_valid`=0, `from_uart_error`=0, state IDLE.
- Start edge seen by FSM 2 cycles after pin edge (synchronizer); edge cycle = t0.
- Bit n (0..7) sampled at t0 + DIV/2 + (n+1)·DIV cycles (±1); stop at t0 + DIV/2 + 9·DIV (10·DIV with parity).
- `from_uart_valid` (or error pulse) asserts the cycle after the stop sample.
- Reset asserted mid-frame: all state cleared next edge; the partial frame is lost, no valid/error; reception resumes on the next falling edge after reset deasserts.
- Back-to-back frames with zero idle gap supported: STOP->IDLE occurs at mid-stop-bit, before the next start edge.

## Configuration
- `UART_RX_PARITY_EN` defined: 8E1 frames, PARITY state present; received parity must equal XOR of the 8 data bits, else parity error.
- Not defined: 8N1, PARITY state and checker absent; the 10th bit time is the stop bit.

## Test plan
- Reset, send 0x55 then 0xA3 at 115200 with ready held high -> two valid cycles, data 0x55 then 0xA3, no error.
- Ready low, send 0x11, 0x22 -> valid with 0x11 held, error pulse at 0x22's stop; raise ready -> 0x11 accepted, valid drops, 0x22 never appears.
- Send 0x7E with stop bit forced 0 -> one error pulse, no valid; following 0x5A -> delivered correctly.
- Low glitch of DIV/4 cycles on idle line -> no valid, no error, FSM back in IDLE.
- Assert reset during bit 4 of 0xFF, release, send 0x3C -> only 0x3C delivered.
- With `UART_RX_PARITY_EN`: send 0x03 with parity 0 -> delivered; with parity 1 -> error pulse, no valid.
